oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite OAM DMA sequencer for the NES CPU bus.
- Detects a CPU write to $4014 and halts the CPU.
- Then masters the CPU bus for 256 read/write pairs: read from page $XX00-$XXFF, write each byte to PPU OAMDATA ($2004).
- Sits beside the 6502 core; its address/rw/data outputs are muxed onto the bus decoder inputs while dma_active is high.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers the DMA; the written data is the source page.
- OAM_DATA_ADDR, 16'h2004, PPU destination register address.
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- clk  in  1  system clock; one CPU bus cycle per clk.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU-driven bus address.
- cpu_rw  in  1  CPU read(1)/write(0).
- cpu_data_i  in  8  CPU write data.
- bus_data_i  in  8  bus decoder read data; valid one clk after the address is presented.
- cpu_halt  out  1  stall request to the CPU core.
- dma_active  out  1  the DMA owns the bus (address/rw/data muxes select DMA).
- dma_addr  out  16  DMA bus address.
- dma_rw  out  1  DMA read(1)/write(0).
- dma_data_o  out  8  DMA write data.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Clock and reset:
  - Single clock domain; synchronous, active-high reset.
  - Reset values: cpu_halt=0, dma_active=0, dma_addr=0, dma_rw=1, dma_data_o=0, done=0.
  - Internal state on reset: state=IDLE, idx=0, page=0, cyc_odd=0.
- cyc_odd toggles every clk after reset and tracks the APU get/put parity.
- Trigger:
  - In IDLE, cpu_rw=0 and cpu_addr==DMA_REG_ADDR latches page<=cpu_data_i and moves to HALT.
  - Triggers in any other state are ignored.
- HALT:
  - cpu_halt=1, dma_active=0.
  - Stay while cpu_rw==0, because the CPU cannot stop on a write cycle.
  - On the first cycle with cpu_rw==1, go to ALIGN.
- ALIGN:
  - Dummy cycle: dma_active=1, dma_rw=1, dma_addr=cpu_addr held from the last CPU read.
  - If cyc_odd==0 this cycle, go to ALIGN2; otherwise go to READ. READ therefore always starts on an even cycle.
- ALIGN2: one more dummy cycle, same outputs as ALIGN; go to READ.
- READ: dma_addr={page, idx[7:0]}, dma_rw=1; go to WRITE.
- WRITE:
  - dma_addr=OAM_DATA_ADDR, dma_rw=0, dma_data_o=bus_data_i, which is the byte returned for the preceding READ through the decoder's one-cycle latency.
  - If idx==XFER_LEN-1, go to DONE; else idx<=idx+1 and go to READ.
- DONE:
  - done=1, dma_active=0, cpu_halt=0, idx<=0; go to IDLE.
  - The CPU resumes in the following cycle.
- Total stolen cycles for XFER_LEN=256: 1 (HALT, with no CPU writes pending) + 1 or 2 (align) + 512 = 514 or 515.
- cpu_halt is high in HALT, ALIGN, ALIGN2, READ and WRITE.
- dma_active is high in ALIGN, ALIGN2, READ and WRITE.
- Source page $00-$1F hits RAM mirrors; any page is legal.
- The page counter wraps within the page; page is never incremented.
- Reset asserted mid-transfer: return to IDLE on the next edge. Outputs take reset values; the partial OAM write is not completed.

Optional Feature:
- Macro OAM_DMA_CYCLE_CNT_EN.
- Defined:
  - Adds output stolen_cycles[15:0].
  - Cleared when a trigger is accepted; +1 each cycle cpu_halt=1.
  - Holds its value after DONE until the next trigger; reset value 0.
- Undefined: the port and counter do not exist; no other behaviour changes.

Decomposition:
- Shared package nes_pkg:
  - typedef enum dma_state_t {IDLE, HALT, ALIGN, ALIGN2, READ, WRITE, DONE}.
  - Constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004, also used by the bus decoder.
- No sub-module. The single FSM with the idx counter is small enough to stay flat.

Test Plan:
- Trigger, even alignment: CPU writes $02 to $4014 while RAM $0200-$02FF holds i^8'hA5; first CPU read lands with cyc_odd=1 at ALIGN → 256 writes to $2004 carrying data 8'hA5, 8'hA4, ...; cpu_halt high exactly 514 cycles; done pulses once.
- Odd alignment: same stimulus shifted one cycle so ALIGN sees cyc_odd=0 → ALIGN2 taken, cpu_halt high 515 cycles, first READ on an even cycle.
- Halt on write: trigger followed by 2 CPU write cycles (cpu_rw=0) → HALT held 2 extra cycles; dma_active stays 0 until cpu_rw=1.
- Ignored retrigger: write $07 to $4014 while in READ → page stays $02, transfer count unchanged at 256.
- Reset mid-transfer: assert rst at idx=100 → next cycle cpu_halt=0, dma_active=0, dma_rw=1; a new trigger restarts at idx=0.
- With OAM_DMA_CYCLE_CNT_EN defined: stolen_cycles reads 514 and 515 after the first two scenarios respectively.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES bus definitions: OAM DMA sequencer states and the two PPU/APU
// register addresses the DMA block and the bus decoder both need.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        ALIGN2,
        READ,
        WRITE,
        DONE
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to $4014 halts the CPU and copies one page to OAMDATA.
// Optional OAM_DMA_CYCLE_CNT_EN adds a stolen_cycles counter output.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  bus_data_i,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_data_o,
    output logic        done
`ifdef OAM_DMA_CYCLE_CNT_EN
    ,
    output logic [15:0] stolen_cycles
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic [7:0] idx;
    logic [7:0] page;
    logic       cyc_odd;
    logic       trigger;

    assign trigger = !cpu_rw && (cpu_addr == DMA_REG_ADDR);

    // The decoder returns read data one clk after the address, so the byte
    // fetched in READ is on bus_data_i during WRITE and is forwarded directly.
    assign dma_data_o = (state == WRITE) ? bus_data_i : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            page       <= '0;
            cyc_odd    <= 1'b0;
            cpu_halt   <= 1'b0;
            dma_active <= 1'b0;
            dma_addr   <= '0;
            dma_rw     <= 1'b1;
            done       <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        page     <= cpu_data_i;
                        cpu_halt <= 1'b1;
                        state    <= HALT;
                    end
                end
                HALT: begin
                    // The CPU only stops on a read cycle; its address is replayed as the dummy read.
                    if (cpu_rw) begin
                        dma_active <= 1'b1;
                        dma_rw     <= 1'b1;
                        dma_addr   <= cpu_addr;
                        state      <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (cyc_odd) begin
                        dma_addr <= {page, idx};
                        state    <= READ;
                    end else begin
                        state <= ALIGN2;
                    end
                end
                ALIGN2: begin
                    dma_addr <= {page, idx};
                    state    <= READ;
                end
                READ: begin
                    dma_addr <= OAM_DATA_ADDR;
                    dma_rw   <= 1'b0;
                    state    <= WRITE;
                end
                WRITE: begin
                    dma_rw <= 1'b1;
                    if (idx == LAST_IDX) begin
                        cpu_halt   <= 1'b0;
                        dma_active <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx      <= idx + 8'd1;
                        dma_addr <= {page, idx + 8'd1};
                        state    <= READ;
                    end
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OAM_DMA_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stolen_cycles <= '0;
        end else if (state == IDLE && trigger) begin
            stolen_cycles <= '0;
        end else if (cpu_halt) begin
            stolen_cycles <= stolen_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: table of single-cycle trigger/halt vectors, then full
// transfers covering alignment parity, halt-on-write, retrigger and mid-transfer reset.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_i;
    logic [7:0]  bus_data_i = 8'h00;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_data_o;
    logic        done;
`ifdef OAM_DMA_CYCLE_CNT_EN
    logic [15:0] stolen_cycles;
`endif

    always #5 clk = ~clk;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_data_i (cpu_data_i),
        .bus_data_i (bus_data_i),
        .cpu_halt   (cpu_halt),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_rw     (dma_rw),
        .dma_data_o (dma_data_o),
        .done       (done)
`ifdef OAM_DMA_CYCLE_CNT_EN
        ,
        .stolen_cycles (stolen_cycles)
`endif
    );

    // Bus decoder model: registered read, content is a fixed function of the address.
    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA7;
    endfunction

    always @(posedge clk) bus_data_i <= bus_byte(dma_active ? dma_addr : cpu_addr);

    // Reference get/put parity: cleared by reset, toggling every clk afterwards.
    logic par;
    always @(posedge clk) par <= rst ? 1'b0 : ~par;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic [3:0]  exp_ctl;   // {cpu_halt, dma_active, dma_rw, done}
        logic        addr_chk;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic run_xfer(input logic [7:0] pg, input logic want_par, input int n_wr,
                            input int retrig_idx, input int abort_idx, input int exp_halt);
        int   halt_cnt;
        int   wr_cnt;
        int   done_cnt;
        logic prev_par;
        bit   finished;
        bit   aborted;
        halt_cnt = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        finished = 1'b0;
        aborted  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ pg ^ 8'hA7);

        cpu_addr   = 16'h8123;
        cpu_rw     = 1'b1;
        cpu_data_i = 8'h00;
        for (int w = 0; w < 3 && par !== want_par; w++) @(negedge clk);
        check("trigger parity", 32'(par), 32'(want_par));

        cpu_addr   = 16'h4014;
        cpu_rw     = 1'b0;
        cpu_data_i = pg;
        prev_par   = par;
        for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
            @(negedge clk);
            if (cpu_halt) halt_cnt++;
            cpu_addr   = 16'h8123;
            cpu_rw     = 1'b1;
            cpu_data_i = 8'h00;
            if (cyc < n_wr) begin
                cpu_addr = 16'h2000 + 16'(cyc);
                cpu_rw   = 1'b0;
            end
            if (cyc <= n_wr) check("halt state", 32'({cpu_halt, dma_active}), 32'(2'b10));
            if (cyc == n_wr + 1)
                check("align cycle", 32'({dma_active, dma_rw, dma_addr}), 32'({1'b1, 1'b1, 16'h8123}));
            if (dma_active && !dma_rw) begin
                if (wr_cnt == 0) check("first read parity", 32'(prev_par), 32'(1'b0));
                wr_cnt++;
                check("write addr", 32'(dma_addr), 32'(16'h2004));
                if (exp_q.size() == 0) check("write overflow", 32'(wr_cnt), 32'(256));
                else check("write data", 32'(dma_data_o), 32'(exp_q.pop_front()));
            end
            if (retrig_idx >= 0 && cyc > n_wr + 1 && dma_active && dma_rw &&
                dma_addr == {pg, 8'(retrig_idx)}) begin
                cpu_addr   = 16'h4014;
                cpu_rw     = 1'b0;
                cpu_data_i = 8'h07;
            end
            if (done_cnt > 0 && !done) finished = 1'b1;
            if (done) begin
                done_cnt++;
                check("done ctl", 32'({cpu_halt, dma_active}), 32'(2'b00));
            end
            if (abort_idx >= 0 && cyc > n_wr + 1 && dma_active && dma_rw &&
                dma_addr == {pg, 8'(abort_idx)}) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort ctl", 32'({cpu_halt, dma_active, dma_rw, done}), 32'(4'b0010));
                aborted  = 1'b1;
                finished = 1'b1;
            end
            prev_par = par;
        end

        if (!aborted) begin
            check("finished in budget", 32'(finished), 32'(1'b1));
            check("halt cycles", 32'(halt_cnt), 32'(exp_halt));
            check("write count", 32'(wr_cnt), 32'(256));
            check("done pulses", 32'(done_cnt), 32'(1));
`ifdef OAM_DMA_CYCLE_CNT_EN
            check("stolen cycles", 32'(stolen_cycles), 32'(exp_halt));
`endif
        end
        exp_q.delete();
        cpu_addr   = 16'h8123;
        cpu_rw     = 1'b1;
        cpu_data_i = 8'h00;
    endtask

    initial begin
        vecs[0] = '{16'h4015, 1'b0, 8'h02, 4'b0010, 1'b1, 16'h0000};
        vecs[1] = '{16'h4014, 1'b1, 8'h02, 4'b0010, 1'b1, 16'h0000};
        vecs[2] = '{16'h0000, 1'b0, 8'h00, 4'b0010, 1'b1, 16'h0000};
        vecs[3] = '{16'h4014, 1'b0, 8'h02, 4'b1010, 1'b0, 16'h0000};
        vecs[4] = '{16'h2000, 1'b0, 8'h55, 4'b1010, 1'b0, 16'h0000};
        vecs[5] = '{16'h2001, 1'b0, 8'h66, 4'b1010, 1'b0, 16'h0000};
        vecs[6] = '{16'h8123, 1'b1, 8'h00, 4'b1110, 1'b1, 16'h8123};

        rst        = 1'b1;
        cpu_addr   = 16'h8123;
        cpu_rw     = 1'b1;
        cpu_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check("reset ctl", 32'({cpu_halt, dma_active, dma_rw, done}), 32'(4'b0010));
        check("reset addr", 32'(dma_addr), 32'(16'h0000));
        check("reset data", 32'(dma_data_o), 32'(8'h00));
`ifdef OAM_DMA_CYCLE_CNT_EN
        check("reset stolen", 32'(stolen_cycles), 32'(0));
`endif
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            cpu_addr   = vecs[i].addr;
            cpu_rw     = vecs[i].rw;
            cpu_data_i = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d ctl", i), 32'({cpu_halt, dma_active, dma_rw, done}),
                  32'(vecs[i].exp_ctl));
            if (vecs[i].addr_chk)
                check($sformatf("vec%0d addr", i), 32'(dma_addr), 32'(vecs[i].exp_addr));
        end

        rst      = 1'b1;
        cpu_addr = 16'h8123;
        cpu_rw   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset from align", 32'({cpu_halt, dma_active, dma_rw, done}), 32'(4'b0010));

        run_xfer(8'h02, 1'b1, 0, 10, -1, 514);
        run_xfer(8'h05, 1'b0, 0, -1, -1, 515);
        run_xfer(8'h06, 1'b1, 2, -1, -1, 516);
        run_xfer(8'h02, 1'b1, 0, -1, 100, 0);
        run_xfer(8'h03, 1'b0, 0, -1, -1, 515);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
